// File: rtl/bel_avl_mux.sv
// bel_avl_mux: Avalon-MM 1-master to N-slave router with in-order pipelined reads.
// Unmapped regions are answered internally (zero data, one-cycle latency) and flagged in err.
module bel_avl_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int SEL_LSB    = 8,
  parameter int SEL_WIDTH  = 2,
  parameter int MAX_PEND   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AWIDTH-1:0]            m_address,
  input  logic                         m_read,
  input  logic                         m_write,
  input  logic [DWIDTH-1:0]            m_writedata,
  output logic                         m_waitrequest,
  output logic [DWIDTH-1:0]            m_readdata,
  output logic                         m_readdatavalid,
  output logic [AWIDTH-1:0]            s_address,
  output logic [DWIDTH-1:0]            s_writedata,
  output logic [NUM_SLAVES-1:0]        s_read,
  output logic [NUM_SLAVES-1:0]        s_write,
  input  logic [NUM_SLAVES-1:0]        s_waitrequest,
  input  logic [NUM_SLAVES*DWIDTH-1:0] s_readdata,
  input  logic [NUM_SLAVES-1:0]        s_readdatavalid,
  input  logic                         err_clr,
  output logic [1:0]                   err
);
  localparam int TW = SEL_WIDTH + 1;
  localparam int CW = $clog2(MAX_PEND + 1);
  localparam logic [TW-1:0] U = TW'(NUM_SLAVES);
  logic [TW-1:0] raw_sel, tgt, pend_sel_q, pend_sel_d;
  logic [CW-1:0] pend_cnt_q, pend_cnt_d;
  logic          u_rsp_q, u_rsp_d;
  logic [1:0]    err_q, err_d;
  logic          rd, unmapped, stall_rd, slv_wait, acc_rd, rsp, spur;
  assign s_address   = m_address;
  assign s_writedata = m_writedata;
  assign err         = err_q;
  always_comb begin
    raw_sel  = {1'b0, m_address[SEL_LSB +: SEL_WIDTH]};
    unmapped = raw_sel >= U;
    tgt      = unmapped ? U : raw_sel;
    // a read issued together with a write is dropped; the write wins
    rd       = m_read & ~m_write;
    stall_rd = rd & (pend_cnt_q == CW'(MAX_PEND) | (pend_cnt_q != '0 & tgt != pend_sel_q));
    slv_wait   = 1'b0;
    rsp        = pend_sel_q == U & u_rsp_q;
    m_readdata = '0;
    spur       = 1'b0;
    s_read     = '0;
    s_write    = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      slv_wait   = slv_wait | (tgt == TW'(i) & s_waitrequest[i]);
      s_read[i]  = rd & tgt == TW'(i) & ~stall_rd;
      s_write[i] = m_write & tgt == TW'(i);
      m_readdata = pend_sel_q == TW'(i) ? s_readdata[i*DWIDTH +: DWIDTH] : m_readdata;
      rsp        = pend_sel_q == TW'(i) ? (pend_cnt_q != '0 & s_readdatavalid[i]) : rsp;
      spur       = spur | (s_readdatavalid[i] & (pend_cnt_q == '0 | pend_sel_q != TW'(i)));
    end
    m_waitrequest   = stall_rd | ((rd | m_write) & slv_wait);
    m_readdatavalid = rsp;
    acc_rd     = rd & ~m_waitrequest;
    pend_sel_d = acc_rd ? tgt : pend_sel_q;
    pend_cnt_d = pend_cnt_q + CW'(acc_rd) - CW'(rsp);
    u_rsp_d    = acc_rd & unmapped;
    err_d      = (err_q & {2{~err_clr}}) | {spur, unmapped & (acc_rd | m_write)};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt_q <= '0;
      pend_sel_q <= '0;
      u_rsp_q    <= 1'b0;
      err_q      <= '0;
    end else begin
      pend_cnt_q <= pend_cnt_d;
      pend_sel_q <= pend_sel_d;
      u_rsp_q    <= u_rsp_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_bel_avl_mux.sv
// tb_bel_avl_mux: directed and random checks of bel_avl_mux against fixed-latency slave models
// and an in-order expected-response queue built from a reference memory.
module tb_bel_avl_mux;
  localparam int N = 4, AW = 32, DW = 32;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [AW-1:0] m_address = '0;
  logic m_read = 0, m_write = 0, err_clr = 0;
  logic [DW-1:0] m_writedata = '0;
  logic m_waitrequest, m_readdatavalid;
  logic [DW-1:0] m_readdata, s_writedata;
  logic [AW-1:0] s_address;
  logic [N-1:0] s_read, s_write, s_wait = '0, s_rdv = '0, inj = '0, rdv_in;
  logic [N*DW-1:0] s_rdata = '0;
  logic [1:0] err;
  assign rdv_in = s_rdv | inj;
  bel_avl_mux #(.NUM_SLAVES(N)) dut (
    .clk(clk), .rst(rst), .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .s_address(s_address), .s_writedata(s_writedata),
    .s_read(s_read), .s_write(s_write), .s_waitrequest(s_wait), .s_readdata(s_rdata),
    .s_readdatavalid(rdv_in), .err_clr(err_clr), .err(err));
  // three-slave instance sharing the master side: region 3 is unmapped there
  logic d3_wait, d3_rdv;
  logic [DW-1:0] d3_rdata, d3_swd;
  logic [AW-1:0] d3_saddr;
  logic [2:0] d3_sread, d3_swrite;
  logic [1:0] d3_err;
  bel_avl_mux #(.NUM_SLAVES(3)) dut3 (
    .clk(clk), .rst(rst), .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_waitrequest(d3_wait), .m_readdata(d3_rdata),
    .m_readdatavalid(d3_rdv), .s_address(d3_saddr), .s_writedata(d3_swd),
    .s_read(d3_sread), .s_write(d3_swrite), .s_waitrequest(s_wait[2:0]),
    .s_readdata(s_rdata[3*DW-1:0]), .s_readdatavalid(rdv_in[2:0]), .err_clr(err_clr), .err(d3_err));
  int n_chk = 0, n_pass = 0;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic [DW-1:0] dflt(int i, logic [AW-1:0] a);
    return {4'(i), 12'hBEE, a[15:0]};
  endfunction
  // slave models: fixed latency per slave, memory per slave
  typedef struct {int due; logic [DW-1:0] d;} rsp_t;
  rsp_t sq[N][$];
  int lat[N] = '{1, 1, 1, 1};
  logic [DW-1:0] smem [logic [35:0]];
  int cyc = 0;
  always @(posedge clk) begin
    rsp_t r;
    logic [35:0] k;
    cyc++;
    for (int i = 0; i < N; i++) begin
      k = {4'(i), s_address};
      if (s_write[i] & ~s_wait[i]) smem[k] = s_writedata;
      if (s_read[i] & ~s_wait[i]) sq[i].push_back('{cyc + lat[i] - 1, smem.exists(k) ? smem[k] : dflt(i, s_address)});
      if (sq[i].size() != 0 && sq[i][0].due == cyc) begin
        r = sq[i].pop_front();
        s_rdv[i] <= 1'b1;
        s_rdata[i*DW +: DW] <= r.d;
      end else s_rdv[i] <= 1'b0;
    end
  end
  // reference: region from address bits, responses in acceptance order
  logic [DW-1:0] rmem [logic [35:0]];
  logic [DW-1:0] exp_q[$];
  function automatic logic [35:0] key(logic [AW-1:0] a);
    return {4'(a[9:8]), a};
  endfunction
  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return rmem.exists(key(a)) ? rmem[key(a)] : dflt(int'(a[9:8]), a);
  endfunction
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (m_readdatavalid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", m_readdatavalid, 0);
        else chk("rsp_data", m_readdata, exp_q.pop_front());
      end
      if (m_read & ~m_write & ~m_waitrequest) exp_q.push_back(ref_rd(m_address));
      if (m_write & ~m_waitrequest) rmem[key(m_address)] = m_writedata;
    end
  end
  task automatic step; @(posedge clk); #1; endtask
  task automatic smp; @(negedge clk); endtask
  task automatic idle; m_read = 0; m_write = 0; endtask
  task automatic drain;
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin step; t++; end
    chk("drain_left", exp_q.size(), 0);
    smp;
    chk("drain_pend", dut.pend_cnt_q, 0);
  endtask
  task automatic clr_err; step; err_clr = 1; step; err_clr = 0; endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] a;
    bit wr;
    int t;
    step; smp;
    chk("rst_rdv", m_readdatavalid, 0); chk("rst_err", err, 0);
    chk("rst_pend", dut.pend_cnt_q, 0); chk("rst_wait", m_waitrequest, 0);
    step; rst = 0;
    // 1: write then read back through slave 1
    step; m_write = 1; m_address = 32'h104; m_writedata = 32'h12345678;
    smp; chk("t1_swrite", s_write, 4'b0010); chk("t1_wait", m_waitrequest, 0);
    step; m_write = 0; m_read = 1;
    smp; chk("t1_sread", s_read, 4'b0010); chk("t1_swrite_once", s_write, 0);
    step; idle;
    smp; chk("t1_rdv", m_readdatavalid, 1); chk("t1_data", m_readdata, 32'h12345678);
    step; smp; chk("t1_pend", dut.pend_cnt_q, 0);
    // 2: four back-to-back reads, fifth stalls at MAX_PEND
    lat[1] = 4;
    for (int i = 0; i < 4; i++) begin
      step; m_read = 1; m_address = 32'h100 + 32'(4 * i);
      smp; chk("t2_nostall", m_waitrequest, 0);
    end
    step; m_address = 32'h110;
    smp; chk("t2_stall", m_waitrequest, 1); chk("t2_first_rsp", m_readdatavalid, 1);
    step; smp; chk("t2_acc5", m_waitrequest, 0);
    step; idle; drain;
    // 3: switching slaves waits for outstanding responses
    lat[1] = 2; lat[2] = 1;
    step; m_read = 1; m_address = 32'h100;
    smp; chk("t3_acc1", m_waitrequest, 0);
    step; m_address = 32'h200;
    smp; chk("t3_stall", m_waitrequest, 1); chk("t3_no_rsp", m_readdatavalid, 0);
    step; smp; chk("t3_rsp", m_readdatavalid, 1); chk("t3_hold", m_waitrequest, 1);
    step; smp; chk("t3_acc2", m_waitrequest, 0); chk("t3_sread", s_read, 4'b0100);
    step; idle; drain;
    // 4: unmapped read on the three-slave instance
    step; m_read = 1; m_address = 32'h300;
    smp; chk("t4_sread", d3_sread, 0); chk("t4_wait", d3_wait, 0);
    step; idle;
    smp; chk("t4_rdv", d3_rdv, 1); chk("t4_data", d3_rdata, 0); chk("t4_err", d3_err, 2'b01);
    chk("t4_main_err", err, 0);
    step; smp; chk("t4_one_rsp", d3_rdv, 0);
    clr_err; smp; chk("t4_clr", d3_err, 0);
    drain;
    // 5: spurious slave response with nothing pending
    step; inj = 4'b1000;
    smp; chk("t5_no_fwd", m_readdatavalid, 0);
    step; inj = 0;
    smp; chk("t5_err", err, 2'b10);
    step; inj = 4'b1000; err_clr = 1;
    step; inj = 0; err_clr = 0;
    smp; chk("t5_set_wins", err, 2'b10);
    clr_err; smp; chk("t5_clr", err, 0);
    // 6: reset with two reads outstanding
    lat[1] = 3;
    step; m_read = 1; m_address = 32'h108;
    step; m_address = 32'h10C;
    smp; chk("t6_acc2", m_waitrequest, 0);
    step; idle; rst = 1;
    smp; chk("t6_pend_rst", dut.pend_cnt_q, 0);
    step; rst = 0;
    smp; chk("t6_no_rsp1", m_readdatavalid, 0); chk("t6_pend", dut.pend_cnt_q, 0);
    step; smp; chk("t6_no_rsp2", m_readdatavalid, 0);
    step; smp; chk("t6_err", err, 2'b10);
    clr_err;
    // random traffic with slave stalls and varied latencies
    for (int i = 0; i < N; i++) lat[i] = $urandom_range(1, 4);
    for (int n = 0; n < 150; n++) begin
      a = {22'h0, 2'($urandom_range(0, 3)), 2'b00, 4'($urandom_range(0, 15)), 2'b00};
      wr = $urandom_range(0, 3) == 0;
      step; s_wait = 4'($urandom) & 4'($urandom);
      m_address = a; m_writedata = $urandom; m_write = wr; m_read = ~wr;
      smp; chk("rnd_route", (s_read | s_write) & ~(4'b1 << a[9:8]), 0);
      t = 0;
      while (m_waitrequest && t < 60) begin
        step; s_wait = 4'($urandom) & 4'($urandom);
        smp; t++;
      end
      chk("rnd_accept", m_waitrequest, 0);
    end
    step; idle; s_wait = 0;
    drain;
    chk("rnd_err", err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
